// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: one inverse round per clock,
// round keys fetched from an external combinational store addressed by rk_idx.
module aes_inv_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] NR_IDX = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            else      acc = acc;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as a^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] p;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    state_t       state_r;
    state_t       state_nx_s;
    logic [127:0] st_r;
    logic [127:0] out_data_r;
    logic [3:0]   rnd_r;
    logic [127:0] isr_sub_s;
    logic [127:0] round_s;
    logic [127:0] final_s;

    assign isr_sub_s = inv_sub_bytes(inv_shift_rows(st_r));
    assign round_s   = inv_mix_columns(isr_sub_s ^ rk_data);
    assign final_s   = isr_sub_s ^ rk_data;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign out_data  = out_data_r;

    // Round-key index requested from the key store in the current state.
    always_comb begin
        rk_idx = 4'd0;
        case (state_r)
            IDLE:    rk_idx = NR_IDX;
            ROUND:   rk_idx = rnd_r;
            default: rk_idx = 4'd0;
        endcase
    end

    // Next-state logic; abort only cancels work in flight, never a finished result.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nx_s = ROUND;
                else          state_nx_s = IDLE;
            end
            ROUND: begin
                if (abort)              state_nx_s = IDLE;
                else if (rnd_r <= 4'd1) state_nx_s = FINAL;
                else                    state_nx_s = ROUND;
            end
            FINAL: begin
                if (abort) state_nx_s = IDLE;
                else       state_nx_s = DONE;
            end
            DONE: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nx_s;
    end

    // Datapath: state block, round counter and the held plaintext.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r       <= 128'h0;
            rnd_r      <= 4'd0;
            out_data_r <= 128'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        st_r  <= in_data ^ rk_data;
                        rnd_r <= NR_IDX - 4'd1;
                    end
                end
                ROUND: begin
                    if (!abort) begin
                        st_r <= round_s;
                        if (rnd_r >= 4'd2) rnd_r <= rnd_r - 4'd1;
                    end
                end
                FINAL: begin
                    if (!abort) begin
                        st_r       <= final_s;
                        out_data_r <= final_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: a forward AES-128 model produces ciphertexts whose
// plaintexts the DUT must recover; handshake, abort and reset behaviour checked per task.
module tb_aes_inv_round_ctrl;
    localparam int NR = 10;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic [127:0] rk_tbl [0:NR];
    logic [7:0]   sbox [0:255];
    int tests_run;
    int tests_failed;

    aes_inv_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk_data(rk_data), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rk_data = (int'(rk_idx) <= NR) ? rk_tbl[rk_idx] : 128'h0;

    function automatic logic [7:0] dbl(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = dbl(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return 8'((v << k) | (v >> (8 - k)));
    endfunction

    // Forward S-box from a brute-force multiplicative inverse and the forward affine map.
    task automatic build_sbox();
        logic [7:0] inv [0:255];
        logic [7:0] y;
        inv[0] = 8'h00;
        for (int x = 1; x < 256; x++) begin
            inv[x] = 8'h00;
            for (int z = 1; z < 256; z++) begin
                if (gmul(8'(x), 8'(z)) == 8'h01) inv[x] = 8'(z);
            end
        end
        for (int x = 0; x < 256; x++) begin
            y = inv[x];
            sbox[x] = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = dbl(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = sbox[s[127 - 8*(r + 4*((c + r) % 4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];      a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];      a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = dbl(a0) ^ dbl(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ dbl(a1) ^ dbl(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ dbl(a2) ^ dbl(a3) ^ a3;
            o[103 - 32*c -: 8] = dbl(a0) ^ a0 ^ a1 ^ a2 ^ dbl(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tbl[0];
        for (int r = 1; r < NR; r++) s = mix(sub_shift(s)) ^ rk_tbl[r];
        return sub_shift(s) ^ rk_tbl[NR];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, follow its rk_idx trace and latency, optionally stall, then drain it.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt,
                             input int stall, input string tag);
        int n;
        int exp_rk;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_timeout: in_ready=%b want 1", tag, in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data  = ct;
        tests_run++;
        if (rk_idx !== 4'(NR)) begin
            tests_failed++;
            $display("FAIL %s rk_idx_accept: got %0d want %0d", tag, rk_idx, NR);
        end
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!out_valid && n < 4*NR) begin
            exp_rk = (n < NR - 1) ? NR - 1 - n : 0;
            tests_run++;
            if (rk_idx !== 4'(exp_rk)) begin
                tests_failed++;
                $display("FAIL %s rk_idx_trace[%0d]: got %0d want %0d", tag, n, rk_idx, exp_rk);
            end
            step();
            n++;
        end
        tests_run++;
        if (n != NR) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, NR);
        end
        tests_run++;
        if (out_data !== exp_pt) begin
            tests_failed++;
            $display("FAIL %s out_data: got %h want %h", tag, out_data, exp_pt);
        end
        tests_run++;
        if (rk_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL %s rk_idx_done: got %0d want 0", tag, rk_idx);
        end
        for (int s = 0; s < stall; s++) begin
            abort = 1'b1;
            step();
            tests_run++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp_pt}) begin
                tests_failed++;
                $display("FAIL %s stall[%0d]: valid=%b ready=%b data=%h want 1 0 %h",
                         tag, s, out_valid, in_ready, out_data, exp_pt);
            end
        end
        abort     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL %s release: valid=%b ready=%b want 0 1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({in_ready, out_valid, out_data, rk_idx} !== {1'b1, 1'b0, 128'h0, 4'(NR)}) begin
            tests_failed++;
            $display("FAIL reset_values: ready=%b valid=%b data=%h rk=%0d want 1 0 0 %0d",
                     in_ready, out_valid, out_data, rk_idx, NR);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_c1();
        run_block(C1_CT, C1_PT, 0, "c1");
    endtask

    task automatic test_stall();
        run_block(C1_CT, C1_PT, 5, "stall");
    endtask

    task automatic test_back_to_back();
        int cyc;
        int acc [$];
        logic [127:0] outs [$];
        cyc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        while (outs.size() < 2 && cyc < 80) begin
            if (in_valid && in_ready) acc.push_back(cyc);
            if (out_valid) outs.push_back(out_data);
            step();
            cyc++;
            if (acc.size() >= 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (outs.size() != 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d outputs want 2", outs.size());
        end
        for (int i = 0; i < outs.size(); i++) begin
            tests_run++;
            if (outs[i] !== C1_PT) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: got %h want %h", i, outs[i], C1_PT);
            end
        end
        tests_run++;
        if (acc.size() != 2 || acc[1] - acc[0] != NR + 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d acceptances gap %0d want 2 gap %0d",
                     acc.size(), (acc.size() >= 2) ? acc[1] - acc[0] : -1, NR + 2);
        end
    endtask

    task automatic test_abort();
        int n;
        int seen;
        in_valid = 1'b1;
        in_data  = C1_CT;
        step();
        in_valid = 1'b0;
        n = 0;
        while (rk_idx !== 4'd5 && n < 20) begin step(); n++; end
        tests_run++;
        if (rk_idx !== 4'd5) begin
            tests_failed++;
            $display("FAIL abort_reach: rk_idx=%0d want 5", rk_idx);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, rk_idx} !== {1'b1, 1'b0, 4'(NR)}) begin
            tests_failed++;
            $display("FAIL abort_idle: ready=%b valid=%b rk=%0d want 1 0 %0d",
                     in_ready, out_valid, rk_idx, NR);
        end
        seen = 0;
        repeat (15) begin
            if (out_valid) seen++;
            step();
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
        end
        run_block(C1_CT, C1_PT, 0, "after_abort");
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_data  = C1_CT;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, out_valid, out_data, rk_idx} !== {1'b1, 1'b0, 128'h0, 4'(NR)}) begin
            tests_failed++;
            $display("FAIL async_reset: ready=%b valid=%b data=%h rk=%0d want 1 0 0 %0d",
                     in_ready, out_valid, out_data, rk_idx, NR);
        end
        #1;
        rst = 1'b0;
        step();
        run_block(C1_CT, C1_PT, 0, "after_reset");
    endtask

    task automatic test_in_valid_ignored();
        int n;
        in_valid = 1'b1;
        in_data  = C1_CT;
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = C1_CT ^ {$urandom, $urandom, $urandom, ($urandom | 32'h1)};
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 4*NR) begin step(); n++; end
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, C1_PT}) begin
            tests_failed++;
            $display("FAIL ignore_data: valid=%b data=%h want 1 %h", out_valid, out_data, C1_PT);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        tests_run++;
        if ({in_ready, out_valid, rk_idx} !== {1'b1, 1'b0, 4'(NR)}) begin
            tests_failed++;
            $display("FAIL ignore_no_queue: ready=%b valid=%b rk=%0d want 1 0 %0d",
                     in_ready, out_valid, rk_idx, NR);
        end
    endtask

    task automatic test_random();
        logic [127:0] pt;
        for (int i = 0; i < 4; i++) begin
            expand_key({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_block(aes_encrypt(pt), pt, i % 2, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 128'h0;
        abort     = 1'b0;
        out_ready = 1'b0;
        build_sbox();
        expand_key(C1_KEY);
        test_reset();
        test_c1();
        test_stall();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_in_valid_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative AES-128 inverse-cipher sequencer for the ALU's AES datapath. It accepts one 128-bit ciphertext block through a valid/ready handshake. It then drives the existing combinational `inv_shift_rows`, `inv_sub_bytes` and `inv_mix_columns` stages and an internal AddRoundKey XOR, one round per clock. The block supplies the round index to the external round-key store and returns the plaintext through a valid/ready output handshake.

## Interface
Parameters:
- NR, 10, number of rounds. Legal values are 2–14. Round-key indices run NR..0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a ciphertext block is offered on in_data.
- in_ready  out  1  the block can accept a ciphertext; high only in IDLE.
- in_data  in  128  ciphertext. Byte 0 is at [127:120], column-major, as in FIPS-197.
- rk_idx  out  4  round-key index requested this cycle; combinational from FSM state and counter.
- rk_data  in  128  round key for rk_idx. Must be valid in the same cycle (combinational key store).
- abort  in  1  synchronous cancel of the block in flight.
- out_valid  out  1  out_data holds a finished plaintext.
- out_ready  in  1  the consumer takes out_data.
- out_data  out  128  plaintext, registered.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- Datapath register `st` (128 bits) and round counter `rnd` (4 bits).
- IDLE
  - rk_idx = NR and in_ready = 1.
  - On in_valid: st <= in_data ^ rk_data (initial AddRoundKey), rnd <= NR-1, go to ROUND.
- ROUND
  - rk_idx = rnd.
  - st <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(st)) ^ rk_data).
  - If rnd == 1, go to FINAL; otherwise rnd <= rnd-1.
- FINAL
  - rk_idx = 0.
  - st <= inv_sub_bytes(inv_shift_rows(st)) ^ rk_data. Go to DONE.
- DONE
  - out_valid = 1, out_data = st, rk_idx = 0.
  - On out_ready: go to IDLE. out_data keeps its last value.
  - Stay in DONE until out_ready; st is frozen.
- abort
  - In ROUND or FINAL, abort forces IDLE on the next edge. st is not updated and no out_valid is produced.
  - abort in IDLE or DONE is ignored. A pending result is never dropped.
- in_ready is low outside IDLE. in_valid asserted in other states is ignored and does not queue.
- Back-to-back blocks:
  - DONE→IDLE costs one cycle.
  - There is no combinational path from out_ready to in_ready.
- All XORs are 128-bit bitwise. The counter never wraps: `rnd` is only decremented while in ROUND with rnd ≥ 2.

## Timing
- Reset values:
  - FSM = IDLE, st = 0, rnd = 0.
  - out_valid = 0, out_data = 0, in_ready = 1, rk_idx = NR.
- Reset mid-operation clears everything immediately (asynchronous). No output is produced for the interrupted block.
- Latency, with acceptance at edge E0 (in_valid & in_ready sampled high):
  - ROUND cycles follow for NR-1 edges, then FINAL for 1 edge.
  - out_valid rises after edge E0+NR, i.e. 10 cycles for NR = 10.
- Throughput is one block per NR+2 cycles, given out_ready is held high.
- rk_idx sequence starting in the acceptance cycle: NR, NR-1, …, 1, 0. The value changes only on clock edges.
- Critical path: st → inv_shift_rows → inv_sub_bytes → XOR → inv_mix_columns → st.

## Test plan
- FIPS-197 C.1 vector, with the bench modelling the key store from the key expansion of key 000102030405060708090a0b0c0d0e0f.
  - Stimulus: in_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data = 00112233445566778899aabbccddeeff, with out_valid exactly 10 cycles after acceptance.
  - Required rk_idx trace: 10, 9, …, 0.
- Output stall: hold out_ready = 0 for 5 cycles after out_valid.
  - Required: out_valid and out_data remain stable, in_ready stays 0.
  - After out_ready pulses, in_ready = 1 on the next cycle.
- Back-to-back: offer the C.1 ciphertext twice with in_valid held high and out_ready = 1.
  - Required: two identical plaintexts. The second acceptance occurs 12 cycles after the first.
- Abort: assert abort at round index 5.
  - Required: IDLE and in_ready = 1 on the next cycle, and no out_valid.
  - A following C.1 block decrypts correctly.
- Asynchronous reset pulse mid-ROUND, not aligned to clk.
  - Required: outputs go immediately to their reset values, with rk_idx = 10.
  - A new block then completes correctly.
- in_valid asserted during ROUND with a different ciphertext.
  - Required: ignored. The result matches the first block only.
